// File: rtl/switch_pkg.sv
// Shared types for the photonic switch sequencer: FSM state encoding.
package switch_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } state_t;

endpackage

// File: rtl/seq_timer.sv
// Up-counter shared between the blanking and dwell intervals. It wraps to
// zero on the enabled cycle where it reaches the limit, so the count never
// exceeds the limit it is compared against.
module seq_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             hit
);

  assign hit = (cnt == limit);

  // Count enabled cycles; a synchronous clear has priority over counting.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is written only with <= so every flop samples
    // the pre-edge values of its neighbours.
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= hit ? '0 : cnt + WIDTH'(1);
  end

endmodule

// File: rtl/switch_sequencer.sv
// Steps an N-position photonic switch through positions 0..last_step. Each
// position gets a blanking interval (gate low) followed by a dwell interval
// (gate high). All outputs are registered; configuration is latched at start
// so input changes mid-run have no effect.
module switch_sequencer
  import switch_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             repeat_mode,
  input  logic [SEL_W-1:0] last_step,
  input  logic [WIDTH-1:0] blank_limit,
  input  logic [WIDTH-1:0] dwell_limit,
  output logic [SEL_W-1:0] sel,
  output logic             gate,
  output logic             busy,
  output logic             step_strobe,
  output logic             done,
  output logic [WIDTH-1:0] cnt
);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             strobe_nxt;
  logic             done_nxt;
  logic             load_cfg;

  // Configuration captured at the start edge.
  logic [SEL_W-1:0] last_q;
  logic [WIDTH-1:0] blank_q;
  logic [WIDTH-1:0] dwell_q;
  logic             rep_q;

  logic [WIDTH-1:0] limit;
  logic             hit;
  logic             tmr_en;
  logic             tmr_clr;

  // One timer serves both intervals; the limit follows the current state.
  assign limit   = (state == DWELL) ? dwell_q : blank_q;
  assign tmr_en  = en && (state != IDLE);
  assign tmr_clr = stop || (state == IDLE);

  seq_timer #(
    .WIDTH (WIDTH)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (tmr_en),
    .clr   (tmr_clr),
    .limit (limit),
    .cnt   (cnt),
    .hit   (hit)
  );

  // Next-state, next-position and pulse decode; stop overrides everything.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nxt  = state;
    sel_nxt    = sel;
    strobe_nxt = 1'b0;
    done_nxt   = 1'b0;
    load_cfg   = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
      sel_nxt   = '0;
    end else if (en) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            load_cfg  = 1'b1;
            sel_nxt   = '0;
            state_nxt = BLANK;
          end
        end
        BLANK: begin
          if (hit) state_nxt = DWELL;
        end
        DWELL: begin
          if (hit) begin
            if (sel != last_q) begin
              sel_nxt    = sel + SEL_W'(1);
              strobe_nxt = 1'b1;
              state_nxt  = BLANK;
            end else if (rep_q) begin
              sel_nxt    = '0;
              strobe_nxt = 1'b1;
              state_nxt  = BLANK;
            end else begin
              sel_nxt   = '0;
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          sel_nxt   = '0;
        end
      endcase
    end
  end

  // State and registered outputs; gate and busy are decoded from next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= '0;
      gate        <= 1'b0;
      busy        <= 1'b0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      gate        <= (state_nxt == DWELL);
      busy        <= (state_nxt != IDLE);
      step_strobe <= strobe_nxt;
      done        <= done_nxt;
    end
  end

  // Configuration latch, loaded only on an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: these are plain control registers, not memory, so they are reset
    // to give a deterministic power-up configuration.
    if (reset) begin
      last_q  <= '0;
      blank_q <= '0;
      dwell_q <= '0;
      rep_q   <= 1'b0;
    end else if (load_cfg) begin
      last_q  <= last_step;
      blank_q <= blank_limit;
      dwell_q <= dwell_limit;
      rep_q   <= repeat_mode;
    end
  end

endmodule

// File: tb/tb_switch_sequencer.sv
// Scoreboard bench for switch_sequencer. The reference model tracks only the
// number of enabled cycles since the start edge and derives position, phase
// and expected pulses arithmetically from the configured interval lengths.
module tb_switch_sequencer;

  localparam int WIDTH = 4;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             start;
  logic             stop;
  logic             repeat_mode;
  logic [SEL_W-1:0] last_step;
  logic [WIDTH-1:0] blank_limit;
  logic [WIDTH-1:0] dwell_limit;
  logic [SEL_W-1:0] sel;
  logic             gate;
  logic             busy;
  logic             step_strobe;
  logic             done;
  logic [WIDTH-1:0] cnt;

  always #5 clk = ~clk;

  switch_sequencer #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .start       (start),
    .stop        (stop),
    .repeat_mode (repeat_mode),
    .last_step   (last_step),
    .blank_limit (blank_limit),
    .dwell_limit (dwell_limit),
    .sel         (sel),
    .gate        (gate),
    .busy        (busy),
    .step_strobe (step_strobe),
    .done        (done),
    .cnt         (cnt)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int cyc;
    bit is_done;
    int sel;
  } ev_t;

  ev_t evq[$];
  bit  run = 1'b0;
  int  t = 0;
  int  m_last = 0, m_blank = 0, m_dwell = 0;
  bit  m_rep = 1'b0;
  int  start_cyc = 0;

  function automatic int period();
    return m_blank + m_dwell + 2;
  endfunction

  function automatic int phase();
    return t % period();
  endfunction

  function automatic int exp_sel();
    return run ? (t / period()) % (m_last + 1) : 0;
  endfunction

  function automatic int exp_gate();
    return (run && phase() > m_blank) ? 1 : 0;
  endfunction

  function automatic int exp_cnt();
    if (!run) return 0;
    return (phase() > m_blank) ? phase() - m_blank - 1 : phase();
  endfunction

  // Advance one clock edge and apply the sequencing rules to the model.
  task automatic tick();
    ev_t e;
    int  p;
    @(posedge clk);
    cyc++;
    if (reset) begin
      run = 1'b0;
      evq.delete();
    end else if (stop) begin
      run = 1'b0;
    end else if (!run) begin
      if (en && start) begin
        run       = 1'b1;
        t         = 0;
        m_last    = int'(last_step);
        m_blank   = int'(blank_limit);
        m_dwell   = int'(dwell_limit);
        m_rep     = repeat_mode;
        start_cyc = cyc;
      end
    end else if (en) begin
      t++;
      p = period();
      if (t % p == 0) begin
        e.cyc = cyc;
        if (!m_rep && (t / p) == m_last + 1) begin
          run       = 1'b0;
          e.is_done = 1'b1;
          e.sel     = 0;
        end else begin
          e.is_done = 1'b0;
          e.sel     = (t / p) % (m_last + 1);
        end
        evq.push_back(e);
      end
    end
    #1;
  endtask

  // ---------------- monitor ----------------
  int strobes_seen = 0, dones_seen = 0, wraps_seen = 0, last_done_cyc = 0;

  always @(negedge clk) begin : monitor
    ev_t e;
    bit  xs;
    bit  xd;
    if (!reset) begin
      xs = 1'b0;
      xd = 1'b0;
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        check("stale_event", evq[0].cyc, cyc);
        void'(evq.pop_front());
      end
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        e  = evq.pop_front();
        xs = !e.is_done;
        xd = e.is_done;
        check("event_sel", sel, e.sel);
      end
      check("step_strobe", step_strobe, xs);
      check("done", done, xd);
      check("sel", sel, exp_sel());
      check("gate", gate, exp_gate());
      check("busy", busy, run);
      check("cnt", cnt, exp_cnt());
      if (step_strobe) strobes_seen++;
      if (step_strobe && sel == 0) wraps_seen++;
      if (done) begin
        dones_seen++;
        last_done_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_tallies();
    strobes_seen = 0;
    dones_seen   = 0;
    wraps_seen   = 0;
  endtask

  task automatic do_start(input int l, input int b, input int d, input bit r);
    en          = 1'b1;
    stop        = 1'b0;
    last_step   = SEL_W'(l);
    blank_limit = WIDTH'(b);
    dwell_limit = WIDTH'(d);
    repeat_mode = r;
    start       = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n;
    n = 0;
    while (run && n < max_cycles) begin
      tick();
      n++;
    end
    tick();
    check("idle_after_run", busy, 0);
  endtask

  task automatic force_idle();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; repeat_mode = 1'b0;
    last_step = '0; blank_limit = '0; dwell_limit = '0;
    #1;
    check("reset_sel", sel, 0);
    check("reset_gate", gate, 0);
    check("reset_busy", busy, 0);
    check("reset_cnt", cnt, 0);
    tick(); tick();
    reset = 1'b0;
    en = 1'b1;
    tick();

    // 1. one-shot, 4 positions
    clear_tallies();
    do_start(3, 2, 10, 1'b0);
    run_until_idle(200);
    check("t1_strobes", strobes_seen, 3);
    check("t1_dones", dones_seen, 1);
    check("t1_latency", last_done_cyc - start_cyc, 56);

    // 2. repeat mode for 120 cycles, then stop
    clear_tallies();
    do_start(3, 2, 10, 1'b1);
    repeat (120) tick();
    check("t2_dones", dones_seen, 0);
    check("t2_strobes", strobes_seen, 8);
    check("t2_wrap", wraps_seen > 0, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t2_stop_busy", busy, 0);
    check("t2_stop_sel", sel, 0);
    check("t2_stop_gate", gate, 0);
    tick();
    check("t2_no_done", dones_seen, 0);

    // 3. pause for 5 cycles mid-dwell at cnt=4
    clear_tallies();
    do_start(3, 2, 10, 1'b0);
    n = 0;
    while (!(run && exp_gate() == 1 && exp_cnt() == 4) && n < 100) begin
      tick();
      n++;
    end
    check("t3_reached_dwell4", cnt, 4);
    en = 1'b0;
    repeat (5) tick();
    check("t3_frozen_cnt", cnt, 4);
    en = 1'b1;
    run_until_idle(200);
    check("t3_latency", last_done_cyc - start_cyc, 61);

    // 4. async reset mid-blank at sel=2
    do_start(3, 2, 10, 1'b0);
    n = 0;
    while (!(run && exp_sel() == 2 && exp_gate() == 0) && n < 100) begin
      tick();
      n++;
    end
    check("t4_reached_sel2", sel, 2);
    #2;
    reset = 1'b1;
    run = 1'b0;
    evq.delete();
    #1;
    check("t4_async_sel", sel, 0);
    check("t4_async_gate", gate, 0);
    check("t4_async_busy", busy, 0);
    check("t4_async_cnt", cnt, 0);
    check("t4_async_strobe", step_strobe, 0);
    check("t4_async_done", done, 0);
    tick();
    reset = 1'b0;
    tick();
    clear_tallies();
    do_start(3, 2, 10, 1'b0);
    run_until_idle(200);
    check("t4_rerun_latency", last_done_cyc - start_cyc, 56);
    check("t4_rerun_strobes", strobes_seen, 3);

    // 5a. minimum intervals, single position
    clear_tallies();
    do_start(0, 0, 0, 1'b0);
    run_until_idle(20);
    check("t5_min_latency", last_done_cyc - start_cyc, 2);
    check("t5_min_strobes", strobes_seen, 0);

    // 5b. start and stop together
    en = 1'b1; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    check("t5_start_stop_busy", busy, 0);

    // 5c. start while busy is ignored
    do_start(1, 1, 1, 1'b0);
    tick(); tick();
    last_step = 2'd3; blank_limit = 4'd9; dwell_limit = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    run_until_idle(100);
    check("t5_busy_start_latency", last_done_cyc - start_cyc, 8);

    // 6. limit change mid-run takes effect only at next start
    do_start(3, 2, 10, 1'b0);
    repeat (5) tick();
    dwell_limit = 4'd3;
    run_until_idle(200);
    check("t6_latched_latency", last_done_cyc - start_cyc, 56);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until_idle(200);
    check("t6_new_latency", last_done_cyc - start_cyc, 28);

    // Randomized runs with enable gaps, spurious starts and rare stops.
    for (int r = 0; r < 25; r++) begin
      en = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      do_start(int'($urandom_range(3, 0)), int'($urandom_range(15, 0)),
               int'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
      n = 0;
      while (run && n < 250) begin
        en          = ($urandom_range(3, 0) != 0);
        start       = ($urandom_range(15, 0) == 0);
        stop        = ($urandom_range(149, 0) == 0);
        last_step   = SEL_W'($urandom);
        blank_limit = WIDTH'($urandom);
        dwell_limit = WIDTH'($urandom);
        repeat_mode = 1'($urandom);
        tick();
        n++;
      end
      start = 1'b0;
      en    = 1'b1;
      force_idle();
    end

    tick();
    check("events_pending", evq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
